instr_queue: RTL and testbench
==============================

Name: instr_queue

Overview:
- Circular FIFO between the instruction fetcher and the decoder (dc).
- Buffers fetched {pc, instr} pairs and presents the oldest entry to dc as a show-ahead head, with an empty flag.
- Applies backpressure to the fetcher through a full flag.
- Discards all contents on a pipeline flush (branch mispredict or exception redirect).

Parameters:
- DEPTH, 16: number of entries. Must be a power of two, ≥ 4.
- PTR_WIDTH, 4: log2(DEPTH). Width of the head and tail pointers.
- PC_WIDTH, 32: width of pc.
- INSTR_WIDTH, 32: width of instr.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- is_flush_from_rob  input  1  discard all entries this cycle.
- is_valid_from_fetcher  input  1  fetcher offers an entry this cycle.
- pc_from_fetcher  input  PC_WIDTH  pc of the offered entry.
- instr_from_fetcher  input  INSTR_WIDTH  raw instruction word of the offered entry.
- is_full_to_fetcher  output  1  queue refuses pushes this cycle.
- is_stall_from_dc  input  1  decoder cannot accept the head this cycle.
- is_empty_to_dc  output  1  no valid head entry.
- pc_to_dc  output  PC_WIDTH  pc of the head entry.
- instr_to_dc  output  INSTR_WIDTH  instruction word of the head entry.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous, active-high.
- Storage:
  - Two arrays, pc_mem and instr_mem, indexed by head and tail pointers.
  - A registered count of width PTR_WIDTH+1.
  - Pointers wrap modulo DEPTH by natural overflow.
- Flags (derived from the registered count only, never from same-cycle inputs):
  - is_empty_to_dc = (count == 0).
  - is_full_to_fetcher = (count == DEPTH).
- push = is_valid_from_fetcher && !is_full_to_fetcher && !is_flush_from_rob.
  - On push: write {pc, instr} at tail; tail <= tail+1.
  - Entries offered while full are dropped. The fetcher holds and retries them.
- pop = !is_empty_to_dc && !is_stall_from_dc && !is_flush_from_rob.
  - On pop: head <= head+1.
  - The head is consumed at the edge where pop is true.
- Count update:
  - count += push − pop.
  - Push and pop together leave count unchanged, including at count == 1.
  - Push onto an empty queue takes effect at the edge. The entry is visible on pc_to_dc/instr_to_dc the next cycle: 1-cycle fetch-to-dc latency, no same-cycle bypass.
  - Pop at full frees a slot. is_full_to_fetcher deasserts the following cycle; the push in the pop cycle is still refused.
- Head outputs:
  - pc_to_dc and instr_to_dc are driven from mem[head] whenever count > 0.
  - Both are forced to 0 when empty, so dc never sees stale data. dc decodes on every instr change.
  - Head outputs stay stable while is_stall_from_dc=1.
- Flush:
  - Sets head, tail and count to 0 at the edge.
  - Overrides push and pop in the same cycle.
  - From the next cycle: is_empty_to_dc=1, is_full_to_fetcher=0.
- Reset:
  - Same effect as flush.
  - Memory contents are not cleared.
  - Output values after reset: is_empty_to_dc=1, is_full_to_fetcher=0, pc_to_dc=0, instr_to_dc=0.
  - Reset asserted mid-operation behaves identically and has priority over flush, push and pop.
- Ordering: strict FIFO. Entries leave in push order, without reordering or duplication.

Optional Feature:
- Macro: IQ_ALMOST_FULL_EN.
- Defined: is_full_to_fetcher = (count ≥ DEPTH−1). This leaves one slot of slack for a fetcher that responds to backpressure a cycle late.
  - A push arriving when count == DEPTH−1 is still accepted if the fetcher has already issued it, i.e. the push guard uses count < DEPTH.
- Undefined: exact-full behaviour as in Behaviour.

Test Plan:
- Reset, then 3 pushes: pc 0x0,0x4,0x8, instr 0x00100093,0x00200113,0x00300193, dc stalled -> is_empty_to_dc=1 in the cycle after reset deasserts. The cycle after the first push shows pc_to_dc=0x0, instr_to_dc=0x00100093. count=3, and the head is held while stalled.
- Release stall with no new pushes -> dc sees pc 0x0, 0x4, 0x8 on three consecutive cycles, then is_empty_to_dc=1 with pc_to_dc=0, instr_to_dc=0.
- Push 16 entries with dc stalled (DEPTH=16) -> is_full_to_fetcher=1 after the 16th. A 17th entry, pc 0x40, is not stored. After one pop, full clears next cycle; the retried 0x40 is accepted and later emerges after 0x3C.
- At count=1, push and pop in the same cycle -> count stays 1, head advances to the new entry, and no entry is lost.
- Fill 5 entries, assert is_flush_from_rob with a simultaneous push of pc 0x100 -> next cycle is_empty_to_dc=1, count=0, and 0x100 is never emitted. A following push of 0x200 appears as head after 1 cycle.
- Wrap-around: 40 push/pop cycles with random stalls -> output pc sequence equals input sequence across pointer wrap. With IQ_ALMOST_FULL_EN, full asserts at count=15.

Source files
------------

// File: rtl/instr_queue.sv
// Fetch-to-decode instruction FIFO with show-ahead head, full backpressure and flush.
// Define IQ_ALMOST_FULL_EN to raise the full flag one entry early (count >= DEPTH-1).
module instr_queue #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned PTR_WIDTH   = 4,
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   is_flush_from_rob,
    input  logic                   is_valid_from_fetcher,
    input  logic [PC_WIDTH-1:0]    pc_from_fetcher,
    input  logic [INSTR_WIDTH-1:0] instr_from_fetcher,
    output logic                   is_full_to_fetcher,
    input  logic                   is_stall_from_dc,
    output logic                   is_empty_to_dc,
    output logic [PC_WIDTH-1:0]    pc_to_dc,
    output logic [INSTR_WIDTH-1:0] instr_to_dc
);

    localparam logic [PTR_WIDTH:0] CountDepth = DEPTH[PTR_WIDTH:0];

    logic [PC_WIDTH-1:0]    r_pc_mem    [DEPTH];
    logic [INSTR_WIDTH-1:0] r_instr_mem [DEPTH];
    logic [PTR_WIDTH-1:0]   r_head;
    logic [PTR_WIDTH-1:0]   r_tail;
    logic [PTR_WIDTH:0]     r_count;

    logic w_push;
    logic w_pop;
    logic w_empty;
    logic w_full;
    logic w_has_room;

    assign w_empty = (r_count == '0);

`ifdef IQ_ALMOST_FULL_EN
    // One slot of slack: a push already in flight when full rises is still taken.
    assign w_full     = (r_count >= (CountDepth - 1'b1));
    assign w_has_room = (r_count < CountDepth);
`else
    assign w_full     = (r_count == CountDepth);
    assign w_has_room = !w_full;
`endif

    assign w_push = is_valid_from_fetcher && w_has_room && !is_flush_from_rob;
    assign w_pop  = !w_empty && !is_stall_from_dc && !is_flush_from_rob;

    always_ff @(posedge clk) begin
        if (rst || is_flush_from_rob) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is deliberately left uncleared by reset; the head is masked while empty.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_pc_mem[r_tail]    <= pc_from_fetcher;
            r_instr_mem[r_tail] <= instr_from_fetcher;
        end
    end

    assign is_empty_to_dc     = w_empty;
    assign is_full_to_fetcher = w_full;
    assign pc_to_dc           = w_empty ? '0 : r_pc_mem[r_head];
    assign instr_to_dc        = w_empty ? '0 : r_instr_mem[r_head];

endmodule

// File: tb/tb_instr_queue.sv
// Directed self-checking bench for instr_queue; honours IQ_ALMOST_FULL_EN when defined.
module tb_instr_queue;

`ifdef IQ_ALMOST_FULL_EN
    localparam int FullAt = 15;
`else
    localparam int FullAt = 16;
`endif

    logic        clk;
    logic        rst;
    logic        flush;
    logic        valid;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        full;
    logic        stall;
    logic        empty;
    logic [31:0] pc_out;
    logic [31:0] instr_out;

    int n_checks;
    int n_fail;
    logic [31:0] q_pc[$];

    instr_queue #(
        .DEPTH       (16),
        .PTR_WIDTH   (4),
        .PC_WIDTH    (32),
        .INSTR_WIDTH (32)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .is_flush_from_rob     (flush),
        .is_valid_from_fetcher (valid),
        .pc_from_fetcher       (pc_in),
        .instr_from_fetcher    (instr_in),
        .is_full_to_fetcher    (full),
        .is_stall_from_dc      (stall),
        .is_empty_to_dc        (empty),
        .pc_to_dc              (pc_out),
        .instr_to_dc           (instr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b1; pc_in = 32'hDEAD_BEEF; instr_in = 32'h1234_5678;
        cyc();
        cyc();
        rst = 1'b0; valid = 1'b0;
        n_checks++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
        n_checks++;
        if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
        n_checks++;
        if (pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", pc_out); end
        n_checks++;
        if (instr_out !== 32'h0) begin
            n_fail++; $display("FAIL reset_instr got %h want 0", instr_out);
        end
        cyc();
        n_checks++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL post_reset_empty got %b want 1", empty); end
    endtask

    // Three pushes with dc stalled; the head must show the first entry and hold.
    task automatic test_stalled_fill();
        logic [31:0] pcs [3];
        logic [31:0] ins [3];
        pcs = '{32'h0, 32'h4, 32'h8};
        ins = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193};
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1; pc_in = pcs[i]; instr_in = ins[i];
            cyc();
            n_checks++;
            if (empty !== 1'b0 || pc_out !== 32'h0 || instr_out !== 32'h0010_0093) begin
                n_fail++;
                $display("FAIL stalled_head[%0d] got empty=%b pc=%h instr=%h want 0/0/00100093",
                         i, empty, pc_out, instr_out);
            end
        end
        valid = 1'b0;
        cyc();
        n_checks++;
        if (pc_out !== 32'h0 || instr_out !== 32'h0010_0093) begin
            n_fail++; $display("FAIL stalled_hold got pc=%h instr=%h want 0/00100093", pc_out, instr_out);
        end
    endtask

    task automatic test_drain();
        logic [31:0] pcs [3];
        logic [31:0] ins [3];
        pcs = '{32'h0, 32'h4, 32'h8};
        ins = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193};
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (empty !== 1'b0 || pc_out !== pcs[i] || instr_out !== ins[i]) begin
                n_fail++;
                $display("FAIL drain[%0d] got empty=%b pc=%h instr=%h want 0/%h/%h",
                         i, empty, pc_out, instr_out, pcs[i], ins[i]);
            end
            cyc();
        end
        n_checks++;
        if (empty !== 1'b1 || pc_out !== 32'h0 || instr_out !== 32'h0) begin
            n_fail++;
            $display("FAIL drain_empty got empty=%b pc=%h instr=%h want 1/0/0", empty, pc_out, instr_out);
        end
    endtask

    task automatic test_full();
        int k;
        logic [31:0] exp_pc;
        stall = 1'b1;
        for (int i = 0; i < 16; i++) begin
            valid = 1'b1; pc_in = 32'(i * 4); instr_in = 32'hA000_0000 + 32'(i);
            cyc();
            n_checks++;
            if (full !== ((i + 1) >= FullAt)) begin
                n_fail++; $display("FAIL fill_full[%0d] got %b want %b", i, full, (i + 1) >= FullAt);
            end
        end
        // Offered while full: must be dropped.
        pc_in = 32'h40; instr_in = 32'hA000_0010;
        cyc();
        cyc();
        n_checks++;
        if (full !== 1'b1 || pc_out !== 32'h0) begin
            n_fail++; $display("FAIL full_hold got full=%b pc=%h want 1/0", full, pc_out);
        end
        // Pop at full; the same-cycle push is refused.
        stall = 1'b0;
        cyc();
        n_checks++;
        if (full !== (FullAt == 15) || pc_out !== 32'h4) begin
            n_fail++; $display("FAIL pop_at_full got full=%b pc=%h want %b/4", full, pc_out, FullAt == 15);
        end
        cyc();
        valid = 1'b0;
        k = 0;
        exp_pc = 32'h8;
        while (k < 40 && exp_pc <= 32'h40) begin
            n_checks++;
            if (empty !== 1'b0 || pc_out !== exp_pc || instr_out !== 32'hA000_0000 + (exp_pc >> 2)) begin
                n_fail++;
                $display("FAIL full_drain got empty=%b pc=%h instr=%h want pc=%h",
                         empty, pc_out, instr_out, exp_pc);
            end
            exp_pc += 32'h4;
            k++;
            cyc();
        end
        n_checks++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL full_drain_end got empty=%b want 1", empty); end
    endtask

    task automatic test_push_pop_at_one();
        stall = 1'b1; valid = 1'b1; pc_in = 32'h500; instr_in = 32'h11;
        cyc();
        stall = 1'b0; pc_in = 32'h504; instr_in = 32'h22;
        cyc();
        valid = 1'b0; stall = 1'b1;
        n_checks++;
        if (empty !== 1'b0 || pc_out !== 32'h504 || instr_out !== 32'h22) begin
            n_fail++;
            $display("FAIL pp_at_one got empty=%b pc=%h instr=%h want 0/504/22", empty, pc_out, instr_out);
        end
        cyc();
        stall = 1'b0;
        cyc();
        n_checks++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL pp_at_one_count got empty=%b want 1", empty); end
    endtask

    task automatic test_flush();
        stall = 1'b1; valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pc_in = 32'h600 + 32'(4 * i); instr_in = 32'h55;
            cyc();
        end
        flush = 1'b1; pc_in = 32'h100; instr_in = 32'h99;
        cyc();
        flush = 1'b0; valid = 1'b0;
        n_checks++;
        if (empty !== 1'b1 || full !== 1'b0 || pc_out !== 32'h0) begin
            n_fail++; $display("FAIL flush got empty=%b full=%b pc=%h want 1/0/0", empty, full, pc_out);
        end
        cyc();
        n_checks++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL flush_push_dropped got empty=%b want 1", empty); end
        valid = 1'b1; pc_in = 32'h200; instr_in = 32'h33;
        cyc();
        valid = 1'b0;
        n_checks++;
        if (empty !== 1'b0 || pc_out !== 32'h200 || instr_out !== 32'h33) begin
            n_fail++;
            $display("FAIL post_flush_head got empty=%b pc=%h instr=%h want 0/200/33", empty, pc_out, instr_out);
        end
        stall = 1'b0;
        cyc();
        n_checks++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL post_flush_single got empty=%b want 1", empty); end
    endtask

    // Random stalls across pointer wrap, checked against a queue scoreboard.
    task automatic test_wrap();
        logic [31:0] next_pc;
        logic m_push;
        logic m_pop;
        int k;
        q_pc.delete();
        next_pc = 32'h1000;
        for (int n = 0; n < 40; n++) begin
            valid = 1'b1; pc_in = next_pc; instr_in = ~next_pc;
            stall = ($urandom_range(0, 2) == 0);
            #1;
            n_checks++;
            if (empty !== (q_pc.size() == 0) || full !== (q_pc.size() >= FullAt) ||
                (q_pc.size() != 0 && (pc_out !== q_pc[0] || instr_out !== ~q_pc[0]))) begin
                n_fail++;
                $display("FAIL wrap[%0d] got empty=%b full=%b pc=%h instr=%h want size=%0d pc=%h",
                         n, empty, full, pc_out, instr_out, q_pc.size(),
                         (q_pc.size() != 0) ? q_pc[0] : 32'h0);
            end
            m_push = (q_pc.size() < 16);
            m_pop  = (q_pc.size() != 0) && !stall;
            cyc();
            if (m_pop) void'(q_pc.pop_front());
            if (m_push) begin
                q_pc.push_back(next_pc);
                next_pc += 32'h4;
            end
        end
        valid = 1'b0; stall = 1'b0;
        k = 0;
        while (k < 40 && q_pc.size() != 0) begin
            n_checks++;
            if (empty !== 1'b0 || pc_out !== q_pc[0]) begin
                n_fail++; $display("FAIL wrap_drain got empty=%b pc=%h want 0/%h", empty, pc_out, q_pc[0]);
            end
            void'(q_pc.pop_front());
            k++;
            cyc();
        end
        n_checks++;
        if (empty !== 1'b1 || q_pc.size() != 0) begin
            n_fail++; $display("FAIL wrap_end got empty=%b left=%0d want 1/0", empty, q_pc.size());
        end
    endtask

    task automatic test_reset_mid();
        stall = 1'b1; valid = 1'b1; pc_in = 32'h700; instr_in = 32'h77;
        cyc();
        cyc();
        rst = 1'b1; flush = 1'b0; stall = 1'b0;
        cyc();
        rst = 1'b0; valid = 1'b0;
        n_checks++;
        if (empty !== 1'b1 || full !== 1'b0 || pc_out !== 32'h0 || instr_out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid got empty=%b full=%b pc=%h instr=%h want 1/0/0/0",
                     empty, full, pc_out, instr_out);
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b1; flush = 1'b0; valid = 1'b0; stall = 1'b0;
        pc_in = '0; instr_in = '0;
        test_reset();
        test_stalled_fill();
        test_drain();
        test_full();
        test_push_pop_at_one();
        test_flush();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
